viterbi_ber_checker: RTL

//  Downstream scoreboard for the encoder -> channel -> Viterbi decoder chain.
//  - Buffers each encoder input bit as a reference.
//  - Pairs every decoded bit with the oldest buffered reference bit.
//  - Discards the decoder's startup (traceback warm-up) bits.
//  - Counts compared bits, bit errors and the longest error burst, for BER

---
 rtl/viterbi_ber_checker.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
//   Scoreboard that sits behind an encoder -> channel -> Viterbi decoder chain.
//   Every encoder input bit is buffered as a reference. Every decoded bit is
//   paired with the oldest buffered reference bit. The first SKIP_N decoded
//   bits (traceback warm-up) are discarded. After that the block counts
//   compared bits, mismatches and the longest run of consecutive mismatches.
//   A FIFO overflow or underflow parks the block in FAULT until rst or clear_i.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   clear_i         synchronous clear: flush FIFO, zero stats, back to IDLE
//   ref_valid_i     ref_bit_i strobe (encoder enable)
//   ref_bit_i       encoder input bit
//   dec_valid_i     dec_bit_i strobe (decoder output)
//   dec_bit_i       decoded bit
//   bit_cnt_o       compared bits (saturating)
//   err_cnt_o       mismatching bits (saturating)
//   max_burst_o     longest run of consecutive mismatches (saturating)
//   err_pulse_o     one-cycle pulse per mismatch
//   state_o         IDLE=0 SKIP=1 CHECK=2 FAULT=3
//   overflow_o      sticky: push into a full FIFO with no pop
//   underflow_o     sticky: pop from an empty FIFO
module viterbi_ber_checker #(
    parameter int AW     = 4,
    parameter int SKIP_N = 8,
    parameter int CW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          ref_valid_i,
    input  logic          ref_bit_i,
    input  logic          dec_valid_i,
    input  logic          dec_bit_i,
    output logic [CW-1:0] bit_cnt_o,
    output logic [CW-1:0] err_cnt_o,
    output logic [CW-1:0] max_burst_o,
    output logic          err_pulse_o,
    output logic [1:0]    state_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam int DEPTH = 1 << AW;
    localparam int SKW   = (SKIP_N < 2) ? 1 : $clog2(SKIP_N);
    localparam logic [SKW-1:0] SKIP_LAST = (SKIP_N == 0) ? '0 : SKW'(SKIP_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        CHECK = 2'd2,
        FAULT = 2'd3
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [SKW-1:0]  skip_cnt_q, skip_cnt_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]   err_cnt_q, err_cnt_d;
    logic [CW-1:0]   max_burst_q, max_burst_d;
    logic [CW-1:0]   run_cnt_q, run_cnt_d;
    logic            err_pulse_q, err_pulse_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    // Reference storage is data only; it is never reset.
    logic            mem_q [DEPTH];
    logic            wr_en;

    logic            fifo_empty, fifo_full, rd_bit;
    logic            push_req, pop_req, pop_ok, do_push;
    logic            underflow_ev, overflow_ev, compare;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_bit     = mem_q[rd_ptr_q[AW-1:0]];

    assign push_req     = ref_valid_i && (state_q != FAULT);
    assign pop_req      = dec_valid_i && ((state_q == SKIP) || (state_q == CHECK));
    // No bypass: a pop on an empty FIFO is an underflow even with a same-cycle push.
    assign underflow_ev = pop_req && fifo_empty;
    assign pop_ok       = pop_req && !fifo_empty;
    // A same-cycle pop frees a slot, so push+pop is legal when full.
    assign overflow_ev  = push_req && fifo_full && !pop_ok;
    assign do_push      = push_req && !overflow_ev;
    assign compare      = pop_ok && (state_q == CHECK);

    // Stage 0: FIFO control, FSM and statistic updates
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        skip_cnt_d  = skip_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        max_burst_d = max_burst_q;
        run_cnt_d   = run_cnt_q;
        err_pulse_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;

        if (clear_i) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            skip_cnt_d  = '0;
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            max_burst_d = '0;
            run_cnt_d   = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ref_valid_i) begin
                        state_d = (SKIP_N == 0) ? CHECK : SKIP;
                    end
                end
                SKIP: begin
                    if (pop_ok) begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                        if (skip_cnt_q == SKIP_LAST) begin
                            state_d = CHECK;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (underflow_ev) begin
                underflow_d = 1'b1;
                state_d     = FAULT;
            end
            if (overflow_ev) begin
                overflow_d = 1'b1;
                state_d    = FAULT;
            end

            if (compare) begin
                bit_cnt_d = sat_inc(bit_cnt_q);
                if (rd_bit != dec_bit_i) begin
                    err_cnt_d   = sat_inc(err_cnt_q);
                    run_cnt_d   = sat_inc(run_cnt_q);
                    err_pulse_d = 1'b1;
                    if (run_cnt_d > max_burst_q) begin
                        max_burst_d = run_cnt_d;
                    end
                end else begin
                    run_cnt_d = '0;
                end
            end
        end
    end

    // Stage 1: registered state and results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            skip_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            max_burst_q <= '0;
            run_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            skip_cnt_q  <= skip_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            max_burst_q <= max_burst_d;
            run_cnt_q   <= run_cnt_d;
            err_pulse_q <= err_pulse_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ref_bit_i;
        end
    end

    assign bit_cnt_o   = bit_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign max_burst_o = max_burst_q;
    assign err_pulse_o = err_pulse_q;
    assign state_o     = state_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
